// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, optional gshare indexing,
// and zero-latency EX-stage redirect with flush generation.
module branch_predictor #(
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned HIST_BITS = 4,
  parameter int unsigned MODE      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_pc,
  input  logic [31:0] IF_ID_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic             uncond_q [ENTRIES];

  logic [HIST_BITS-1:0] ghr_q;
  logic [IDX_W-1:0]     ghr_ext;
  logic [IDX_W-1:0]     if_idx;
  logic [IDX_W-1:0]     ex_idx;
  logic [TAG_W-1:0]     if_tag;
  logic [TAG_W-1:0]     ex_tag;
  logic                 if_hit;
  logic                 lookup_taken;
  logic                 ex_cf;
  logic                 ex_hit;
  logic                 ctr_we;
  logic                 redirect;
  logic [31:0]          actual_next;
  logic [1:0]           ctr_nxt;

  // Index/tag derivation; history only folds in when gshare is selected
  assign ghr_ext = (MODE == 1) ? IDX_W'(ghr_q) : '0;
  assign if_idx  = IF_pc[IDX_W+1:2] ^ ghr_ext;
  assign ex_idx  = ex_pc[IDX_W+1:2] ^ ghr_ext;
  assign if_tag  = IF_pc[31:IDX_W+2];
  assign ex_tag  = ex_pc[31:IDX_W+2];

  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign lookup_taken = if_hit && (uncond_q[if_idx] || ctr_q[if_idx][1]);

  assign ex_cf       = ex_valid && (ex_is_branch || ex_is_jump);
  assign actual_next = ex_taken ? ex_target : ex_pc + 32'd4;
  assign redirect    = ex_cf && (actual_next != IF_ID_pc);

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ctr_we = ex_cf && (ex_taken || ex_hit);

  // Fetch steering: EX redirect overrides the BTB prediction
  always_comb begin
    next_pc     = IF_pc + 32'd4;
    pred_taken  = 1'b0;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    if (reset) begin
      if (redirect) begin
        next_pc     = actual_next;
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
      end else if (lookup_taken) begin
        next_pc    = target_q[if_idx];
        pred_taken = 1'b1;
      end
    end
  end

  // New allocations start weakly taken; hits saturate in either direction
  always_comb begin
    ctr_nxt = 2'b10;
    if (ex_hit) begin
      if (ex_taken) begin
        ctr_nxt = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
      end else begin
        ctr_nxt = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
      ghr_q          <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_cf && ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
      end
      if (ctr_we) begin
        ctr_q[ex_idx] <= ctr_nxt;
      end
      if (ex_valid && ex_is_branch) begin
        ghr_q <= HIST_BITS'({ghr_q, ex_taken});
      end
      if (redirect && (mispredict_cnt != 32'hFFFF_FFFF)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
    end
  end

  // Payload fields are masked by valid, so they carry no reset
  always_ff @(posedge clk) begin
    if (reset && ex_cf && ex_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
      uncond_q[ex_idx] <= ex_is_jump;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboarded bench for branch_predictor: bimodal instance plus a gshare instance
// sharing one stimulus stream.
module tb_branch_predictor;

  typedef struct packed {
    logic        rst_n;
    logic        mid;
    logic [31:0] if_pc;
    logic [31:0] if_id_pc;
    logic        v;
    logic        br;
    logic        j;
    logic [31:0] ex_pc;
    logic        tk;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic [31:0] npc;
    logic        pt;
    logic        f1;
    logic        f2;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] IF_pc, IF_ID_pc, ex_pc, ex_target;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken;

  logic [31:0] npc0, cnt0, npc1, cnt1;
  logic        pt0, fa0, fb0, pt1, fa1, fb1;

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  exp_t obs;
  exp_t want;
  bit   g_sel = 1'b0;

  branch_predictor dut0 (
    .clk(clk), .reset(reset), .IF_pc(IF_pc), .IF_ID_pc(IF_ID_pc),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .next_pc(npc0), .pred_taken(pt0), .flush_IF_ID(fa0), .flush_ID_EX(fb0),
    .mispredict_cnt(cnt0)
  );

  branch_predictor #(.ENTRIES(16), .HIST_BITS(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .IF_pc(IF_pc), .IF_ID_pc(IF_ID_pc),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .next_pc(npc1), .pred_taken(pt1), .flush_IF_ID(fa1), .flush_ID_EX(fb1),
    .mispredict_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mk(logic rn, logic md, logic [31:0] ifpc, logic [31:0] ifid,
                               logic v, logic b, logic jj, logic [31:0] epc, logic t,
                               logic [31:0] tg);
    stim_t s;
    s = '{rst_n: rn, mid: md, if_pc: ifpc, if_id_pc: ifid, v: v, br: b, j: jj,
          ex_pc: epc, tk: t, tgt: tg};
    return s;
  endfunction

  function automatic stim_t idle(logic [31:0] ifpc);
    return mk(1'b1, 1'b0, ifpc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endfunction

  function automatic stim_t brs(logic [31:0] ifpc, logic [31:0] ifid, logic [31:0] epc,
                                logic t, logic [31:0] tg);
    return mk(1'b1, 1'b0, ifpc, ifid, 1'b1, 1'b1, 1'b0, epc, t, tg);
  endfunction

  function automatic stim_t jmp(logic [31:0] ifpc, logic [31:0] ifid, logic [31:0] epc,
                                logic [31:0] tg);
    return mk(1'b1, 1'b0, ifpc, ifid, 1'b1, 1'b0, 1'b1, epc, 1'b1, tg);
  endfunction

  function automatic exp_t ex(logic [31:0] npc, logic pt, logic f, logic [31:0] cnt);
    exp_t e;
    e = '{npc: npc, pt: pt, f1: f, f2: f, cnt: cnt};
    return e;
  endfunction

  // Drive one cycle of stimulus after the falling edge and sample before the rising edge
  task automatic apply(input stim_t s);
    @(negedge clk);
    reset        = s.rst_n;
    IF_pc        = s.if_pc;
    IF_ID_pc     = s.if_id_pc;
    ex_valid     = s.v;
    ex_is_branch = s.br;
    ex_is_jump   = s.j;
    ex_pc        = s.ex_pc;
    ex_taken     = s.tk;
    ex_target    = s.tgt;
    #1;
    if (s.mid) reset = 1'b0;
    #1;
    obs = g_sel ? exp_t'({npc1, pt1, fa1, fb1, cnt1}) : exp_t'({npc0, pt0, fa0, fb0, cnt0});
  endtask

  task automatic test_reset();
    stim_t st[$];
    st.push_back(mk(1'b0, 1'b0, 32'h100, 32'h104, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd0));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd0));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_reset step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  task automatic test_taken_branch();
    stim_t st[$];
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h200, 1'b0, 1'b1, 32'd0));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 32'd1));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_taken_branch step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  task automatic test_counter_down();
    stim_t st[$];
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b0, 32'h200));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd1));
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b0, 32'h200));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd1));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd1));
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b0, 32'h200));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd1));
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h200, 1'b0, 1'b1, 32'd1));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd2));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_counter_down step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    st.push_back(brs(32'h100, 32'h200, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd2));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 32'd2));
    st.push_back(brs(32'h100, 32'h200, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 32'd2));
    st.push_back(brs(32'h100, 32'h200, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 32'd2));
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b0, 32'h200));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd2));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 32'd2));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_back_to_back step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  task automatic test_jump();
    stim_t st[$];
    st.push_back(jmp(32'h108, 32'h400, 32'h300, 32'h400));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd2));
    st.push_back(idle(32'h300));
    exp_q.push_back(ex(32'h400, 1'b1, 1'b0, 32'd2));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd2));
    st.push_back(jmp(32'h108, 32'h344, 32'h340, 32'h400));
    exp_q.push_back(ex(32'h400, 1'b0, 1'b1, 32'd2));
    st.push_back(idle(32'h340));
    exp_q.push_back(ex(32'h400, 1'b1, 1'b0, 32'd3));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_jump step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t st[$];
    st.push_back(idle(32'hFFFF_FFFC));
    exp_q.push_back(ex(32'h0, 1'b0, 1'b0, 32'd3));
    st.push_back(brs(32'h108, 32'h4, 32'hFFFF_FFFC, 1'b0, 32'h999));
    exp_q.push_back(ex(32'h0, 1'b0, 1'b1, 32'd3));
    st.push_back(mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b1, 1'b0, 1'b0, 32'h500, 1'b1, 32'h999));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd4));
    st.push_back(mk(1'b1, 1'b0, 32'h108, 32'h0, 1'b0, 1'b1, 1'b0, 32'h500, 1'b1, 32'h999));
    exp_q.push_back(ex(32'h10C, 1'b0, 1'b0, 32'd4));
    st.push_back(idle(32'hFFFF_FFFC));
    exp_q.push_back(ex(32'h0, 1'b0, 1'b0, 32'd4));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_wrap step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  // History 0000 -> 0101 via outcomes 0,1,0,1; last taken branch lands at index 3^2=1
  task automatic test_gshare();
    stim_t st[$];
    g_sel = 1'b1;
    st.push_back(mk(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
    exp_q.push_back(ex(32'h14, 1'b0, 1'b0, 32'd0));
    st.push_back(brs(32'h10, 32'h804, 32'h800, 1'b0, 32'h0));
    exp_q.push_back(ex(32'h14, 1'b0, 1'b0, 32'd0));
    st.push_back(brs(32'h10, 32'h950, 32'h900, 1'b1, 32'h950));
    exp_q.push_back(ex(32'h14, 1'b0, 1'b0, 32'd0));
    st.push_back(brs(32'h10, 32'h804, 32'h800, 1'b0, 32'h0));
    exp_q.push_back(ex(32'h14, 1'b0, 1'b0, 32'd0));
    st.push_back(brs(32'h10, 32'h700, 32'h0C, 1'b1, 32'h700));
    exp_q.push_back(ex(32'h14, 1'b0, 1'b0, 32'd0));
    st.push_back(idle(32'h10));
    exp_q.push_back(ex(32'h700, 1'b1, 1'b0, 32'd0));
    st.push_back(idle(32'h50));
    exp_q.push_back(ex(32'h54, 1'b0, 1'b0, 32'd0));
    st.push_back(idle(32'h04));
    exp_q.push_back(ex(32'h08, 1'b0, 1'b0, 32'd0));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_gshare step %0d: actual %h required %h", i, obs, want);
      end
    end
    g_sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    stim_t st[$];
    st.push_back(brs(32'h108, 32'h104, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h200, 1'b0, 1'b1, 32'd0));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h200, 1'b1, 1'b0, 32'd1));
    st.push_back(mk(1'b1, 1'b1, 32'h100, 32'h104, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd0));
    st.push_back(idle(32'h100));
    exp_q.push_back(ex(32'h104, 1'b0, 1'b0, 32'd0));
    st.push_back(idle(32'h0C));
    exp_q.push_back(ex(32'h10, 1'b0, 1'b0, 32'd0));
    foreach (st[i]) begin
      apply(st[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        fails++;
        $display("FAIL test_reset_mid step %0d: actual %h required %h", i, obs, want);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    IF_pc        = 32'h0;
    IF_ID_pc     = 32'h0;
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jump   = 1'b0;
    ex_pc        = 32'h0;
    ex_taken     = 1'b0;
    ex_target    = 32'h0;
    test_reset();
    test_taken_branch();
    test_counter_down();
    test_back_to_back();
    test_jump();
    test_wrap();
    test_gshare();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
